// File: rtl/mem_lsu_pkg.sv
// -----------------------------------------------------------------------------
// mem_lsu_pkg
// Shared definitions for the multi-cycle load/store unit:
//   - load/store opcode encodings (EXE_OP_LOAD_STORE_*)
//   - LSU state encodings (LSU_IDLE / LSU_REQ / LSU_DONE)
//   - small opcode classification helpers
// No ports (package).
// -----------------------------------------------------------------------------
package mem_lsu_pkg;

   localparam int ALU_OP_W = 8;

   localparam logic [ALU_OP_W-1:0] EXE_OP_NOP              = 8'h00;
   localparam logic [ALU_OP_W-1:0] EXE_OP_LOAD_STORE_LB    = 8'h20;
   localparam logic [ALU_OP_W-1:0] EXE_OP_LOAD_STORE_LH    = 8'h21;
   localparam logic [ALU_OP_W-1:0] EXE_OP_LOAD_STORE_LWL   = 8'h22;
   localparam logic [ALU_OP_W-1:0] EXE_OP_LOAD_STORE_LW    = 8'h23;
   localparam logic [ALU_OP_W-1:0] EXE_OP_LOAD_STORE_LBU   = 8'h24;
   localparam logic [ALU_OP_W-1:0] EXE_OP_LOAD_STORE_LHU   = 8'h25;
   localparam logic [ALU_OP_W-1:0] EXE_OP_LOAD_STORE_LWR   = 8'h26;
   localparam logic [ALU_OP_W-1:0] EXE_OP_LOAD_STORE_SB    = 8'h28;
   localparam logic [ALU_OP_W-1:0] EXE_OP_LOAD_STORE_SH    = 8'h29;
   localparam logic [ALU_OP_W-1:0] EXE_OP_LOAD_STORE_SWL   = 8'h2a;
   localparam logic [ALU_OP_W-1:0] EXE_OP_LOAD_STORE_SW    = 8'h2b;
   localparam logic [ALU_OP_W-1:0] EXE_OP_LOAD_STORE_SWR   = 8'h2e;
   localparam logic [ALU_OP_W-1:0] EXE_OP_LOAD_STORE_LL    = 8'h30;
   localparam logic [ALU_OP_W-1:0] EXE_OP_LOAD_STORE_SC    = 8'h38;

   localparam logic [1:0] LSU_IDLE = 2'd0;
   localparam logic [1:0] LSU_REQ  = 2'd1;
   localparam logic [1:0] LSU_DONE = 2'd2;

   function automatic logic is_mem_op(input logic [ALU_OP_W-1:0] op);
      case (op)
         EXE_OP_LOAD_STORE_LB, EXE_OP_LOAD_STORE_LBU, EXE_OP_LOAD_STORE_LH,
         EXE_OP_LOAD_STORE_LHU, EXE_OP_LOAD_STORE_LW, EXE_OP_LOAD_STORE_LWL,
         EXE_OP_LOAD_STORE_LWR, EXE_OP_LOAD_STORE_SB, EXE_OP_LOAD_STORE_SH,
         EXE_OP_LOAD_STORE_SW, EXE_OP_LOAD_STORE_SWL, EXE_OP_LOAD_STORE_SWR,
         EXE_OP_LOAD_STORE_LL, EXE_OP_LOAD_STORE_SC: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic is_store_op(input logic [ALU_OP_W-1:0] op);
      case (op)
         EXE_OP_LOAD_STORE_SB, EXE_OP_LOAD_STORE_SH, EXE_OP_LOAD_STORE_SW,
         EXE_OP_LOAD_STORE_SWL, EXE_OP_LOAD_STORE_SWR,
         EXE_OP_LOAD_STORE_SC: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Alignment faults only exist for the naturally aligned half/word forms;
   // byte and LWL/LWR/SWL/SWR accesses are legal at any offset.
   function automatic logic is_misaligned(input logic [ALU_OP_W-1:0] op,
                                          input logic [1:0] off);
      case (op)
         EXE_OP_LOAD_STORE_LH, EXE_OP_LOAD_STORE_LHU,
         EXE_OP_LOAD_STORE_SH: return off[0];
         EXE_OP_LOAD_STORE_LW, EXE_OP_LOAD_STORE_LL, EXE_OP_LOAD_STORE_SW,
         EXE_OP_LOAD_STORE_SC: return (off != 2'd0);
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// -----------------------------------------------------------------------------
// lsu_lane
// Combinational little-endian byte-lane logic for the load/store unit.
//   Store side: byte enables and replicated/shifted write data.
//   Load side : byte/half extraction, sign/zero extension, LWL/LWR merge.
// Misaligned half/word accesses produce sel=0000 and a zero load result.
// Ports:
//   op     in  load/store opcode
//   off    in  address bits [1:0]
//   reg2   in  store data / LWL-LWR merge operand
//   rword  in  raw 32-bit bus read word
//   sel    out byte enables
//   wdata  out bus write data
//   rdata  out formatted load result
// -----------------------------------------------------------------------------
module lsu_lane
   import mem_lsu_pkg::*;
(
   input  logic [ALU_OP_W-1:0] op,
   input  logic [1:0]          off,
   input  logic [31:0]         reg2,
   input  logic [31:0]         rword,
   output logic [3:0]          sel,
   output logic [31:0]         wdata,
   output logic [31:0]         rdata
);

   logic [31:0] rshift;
   logic [7:0]  rbyte;
   logic [15:0] rhalf;

   assign rshift = rword >> {off, 3'b000};
   assign rbyte  = rshift[7:0];
   assign rhalf  = off[1] ? rword[31:16] : rword[15:0];

   always_comb begin
      sel   = 4'b0000;
      wdata = 32'h0;
      rdata = 32'h0;
      case (op)
         EXE_OP_LOAD_STORE_LB: begin
            sel   = 4'b0001 << off;
            rdata = {{24{rbyte[7]}}, rbyte};
         end
         EXE_OP_LOAD_STORE_LBU: begin
            sel   = 4'b0001 << off;
            rdata = {24'h0, rbyte};
         end
         EXE_OP_LOAD_STORE_LH: begin
            if (!off[0]) begin
               sel   = off[1] ? 4'b1100 : 4'b0011;
               rdata = {{16{rhalf[15]}}, rhalf};
            end
         end
         EXE_OP_LOAD_STORE_LHU: begin
            if (!off[0]) begin
               sel   = off[1] ? 4'b1100 : 4'b0011;
               rdata = {16'h0, rhalf};
            end
         end
         EXE_OP_LOAD_STORE_LW, EXE_OP_LOAD_STORE_LL: begin
            if (off == 2'd0) begin
               sel   = 4'b1111;
               rdata = rword;
            end
         end
         // LWL: memory bytes [off..0] land in the top of the register,
         // the low (3-off) register bytes are kept.
         EXE_OP_LOAD_STORE_LWL: begin
            sel   = 4'b1111 >> ~off;
            rdata = (rword << {~off, 3'b000})
                  | (reg2 & ((32'hFFFF_FFFF >> {off, 3'b000}) >> 8));
         end
         // LWR: memory bytes [3..off] land in the bottom of the register,
         // the top off register bytes are kept.
         EXE_OP_LOAD_STORE_LWR: begin
            sel   = 4'b1111 << off;
            rdata = rshift | (reg2 & ~(32'hFFFF_FFFF >> {off, 3'b000}));
         end
         EXE_OP_LOAD_STORE_SB: begin
            sel   = 4'b0001 << off;
            wdata = {4{reg2[7:0]}};
         end
         EXE_OP_LOAD_STORE_SH: begin
            if (!off[0]) sel = off[1] ? 4'b1100 : 4'b0011;
            wdata = {2{reg2[15:0]}};
         end
         EXE_OP_LOAD_STORE_SW, EXE_OP_LOAD_STORE_SC: begin
            if (off == 2'd0) sel = 4'b1111;
            wdata = reg2;
         end
         EXE_OP_LOAD_STORE_SWL: begin
            sel   = 4'b1111 >> ~off;
            wdata = reg2 >> {~off, 3'b000};
         end
         EXE_OP_LOAD_STORE_SWR: begin
            sel   = 4'b1111 << off;
            wdata = reg2 << {off, 3'b000};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// -----------------------------------------------------------------------------
// mem_lsu
// Multi-cycle load/store unit between EX/MEM and MEM/WB. Issues one access
// over a req/ack bus with arbitrary wait states, stalls the pipeline until
// completion and aborts a hung access after TIMEOUT request cycles.
//
// Bus handshake: bus_req_o rises on entry to REQ and stays high, with
// bus_we_o/bus_addr_o/bus_sel_o/bus_wdata_o held stable, until the first
// cycle bus_ack_i is high at a rising edge; that edge completes the
// transfer (bus_rdata_i sampled with it). ack outside REQ is ignored.
//
// Optional feature: define LSU_ALIGN_EXC_EN to turn misaligned half/word
// accesses into address-error exceptions instead of bus cycles.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   valid_i, aluop_i      live instruction and its load/store opcode
//   mem_addr_i, reg2_i    effective address, store data / merge operand
//   LLbit_i               current LLbit
//   rdata_o, done_o       result, completion strobe
//   LLbit_we_o/value_o    LLbit update (with done_o)
//   stallreq_o            pipeline hold
//   bus_err_o             timeout abort (with done_o)
//   bus_*                 data bus master side
//   excp_adel_o/ades_o    address error (load/store)
//   dbg_state_o           current FSM state
// -----------------------------------------------------------------------------
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid_i,
   input  logic [ALU_OP_W-1:0] aluop_i,
   input  logic [ADDR_W-1:0]   mem_addr_i,
   input  logic [31:0]         reg2_i,
   input  logic                LLbit_i,
   output logic [31:0]         rdata_o,
   output logic                done_o,
   output logic                LLbit_we_o,
   output logic                LLbit_value_o,
   output logic                stallreq_o,
   output logic                bus_err_o,
   output logic                bus_req_o,
   output logic                bus_we_o,
   output logic [ADDR_W-1:0]   bus_addr_o,
   output logic [3:0]          bus_sel_o,
   output logic [31:0]         bus_wdata_o,
   input  logic                bus_ack_i,
   input  logic [31:0]         bus_rdata_i,
   output logic                excp_adel_o,
   output logic                excp_ades_o,
   output logic [1:0]          dbg_state_o
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [1:0]          state_q;
   logic [ALU_OP_W-1:0] op_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [31:0]         reg2_q;
   logic [3:0]          sel_q;
   logic [31:0]         wdata_q;
   logic                we_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [31:0]         result_q;
   logic                err_q;
   logic                llwe_q;
   logic                llval_q;
   logic                kill_q;

   logic                in_idle;
   logic                in_req;
   logic                start;
   logic [ALU_OP_W-1:0] lane_op;
   logic [1:0]          lane_off;
   logic [31:0]         lane_reg2;
   logic [3:0]          lane_sel;
   logic [31:0]         lane_wdata;
   logic [31:0]         lane_rdata;

   assign in_idle = (state_q == LSU_IDLE);
   assign in_req  = (state_q == LSU_REQ);
   assign start   = in_idle && valid_i && is_mem_op(aluop_i);

   // One lane block serves both paths: in IDLE it formats sel/wdata from
   // the live inputs for latching; afterwards it formats the read word
   // against the latched op/offset/merge operand.
   assign lane_op   = in_idle ? aluop_i          : op_q;
   assign lane_off  = in_idle ? mem_addr_i[1:0]  : addr_q[1:0];
   assign lane_reg2 = in_idle ? reg2_i           : reg2_q;

   lsu_lane u_lane (
      .op    (lane_op),
      .off   (lane_off),
      .reg2  (lane_reg2),
      .rword (bus_rdata_i),
      .sel   (lane_sel),
      .wdata (lane_wdata),
      .rdata (lane_rdata)
   );

`ifdef LSU_ALIGN_EXC_EN
   logic adel_q;
   logic ades_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= LSU_IDLE;
         op_q     <= EXE_OP_NOP;
         addr_q   <= '0;
         reg2_q   <= '0;
         sel_q    <= '0;
         wdata_q  <= '0;
         we_q     <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
         llwe_q   <= 1'b0;
         llval_q  <= 1'b0;
         kill_q   <= 1'b0;
`ifdef LSU_ALIGN_EXC_EN
         adel_q   <= 1'b0;
         ades_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            LSU_IDLE: begin
               if (start) begin
                  op_q     <= aluop_i;
                  addr_q   <= mem_addr_i;
                  reg2_q   <= reg2_i;
                  sel_q    <= lane_sel;
                  wdata_q  <= lane_wdata;
                  we_q     <= is_store_op(aluop_i);
                  cnt_q    <= '0;
                  result_q <= '0;
                  err_q    <= 1'b0;
                  llwe_q   <= 1'b0;
                  llval_q  <= 1'b0;
                  kill_q   <= 1'b0;
`ifdef LSU_ALIGN_EXC_EN
                  adel_q   <= 1'b0;
                  ades_q   <= 1'b0;
                  if (is_misaligned(aluop_i, mem_addr_i[1:0])) begin
                     adel_q  <= !is_store_op(aluop_i);
                     ades_q  <= is_store_op(aluop_i);
                     state_q <= LSU_DONE;
                  end else
`endif
                  // SC without a live link fails locally, no bus cycle.
                  if (aluop_i == EXE_OP_LOAD_STORE_SC && !LLbit_i)
                     state_q <= LSU_DONE;
                  else
                     state_q <= LSU_REQ;
               end
            end
            LSU_REQ: begin
               // A flush while the access is in flight: finish the bus
               // cycle but suppress the completion strobe.
               if (!valid_i) kill_q <= 1'b1;
               // ack takes priority over a timeout in the same cycle
               if (bus_ack_i) begin
                  result_q <= (op_q == EXE_OP_LOAD_STORE_SC) ? 32'd1 : lane_rdata;
                  llwe_q   <= (op_q == EXE_OP_LOAD_STORE_LL) ||
                              (op_q == EXE_OP_LOAD_STORE_SC);
                  llval_q  <= (op_q == EXE_OP_LOAD_STORE_LL);
                  state_q  <= LSU_DONE;
               end else if (cnt_q == CNT_LAST) begin
                  err_q    <= 1'b1;
                  result_q <= '0;
                  state_q  <= LSU_DONE;
               end else begin
                  cnt_q    <= cnt_q + CNT_W'(1);
               end
            end
            LSU_DONE: begin
               state_q <= LSU_IDLE;
            end
            default: begin
               state_q <= LSU_IDLE;
            end
         endcase
      end
   end

   assign done_o        = (state_q == LSU_DONE) && valid_i && !kill_q;
   assign rdata_o       = done_o ? result_q : 32'h0;
   assign LLbit_we_o    = done_o && llwe_q;
   assign LLbit_value_o = done_o && llval_q;
   assign bus_err_o     = done_o && err_q;
   assign stallreq_o    = !rst && valid_i && is_mem_op(aluop_i) &&
                          (state_q != LSU_DONE);

   assign bus_req_o     = in_req;
   assign bus_we_o      = in_req && we_q;
   assign bus_addr_o    = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign bus_sel_o     = in_req ? sel_q   : 4'b0000;
   assign bus_wdata_o   = in_req ? wdata_q : 32'h0;
   assign dbg_state_o   = state_q;

`ifdef LSU_ALIGN_EXC_EN
   assign excp_adel_o   = done_o && adel_q;
   assign excp_ades_o   = done_o && ades_q;
`else
   assign excp_adel_o   = 1'b0;
   assign excp_ades_o   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// -----------------------------------------------------------------------------
// tb_mem_lsu
// Directed-vector bench for mem_lsu. Clock/reset block, one driver task that
// runs a complete access with a programmable ack delay, an expected-result
// queue checked on every done_o, and a final summary line.
// -----------------------------------------------------------------------------
module tb_mem_lsu;
   import mem_lsu_pkg::*;

   localparam int ADDR_W  = 32;
   localparam int TIMEOUT = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic                valid_i;
   logic [ALU_OP_W-1:0] aluop_i;
   logic [ADDR_W-1:0]   mem_addr_i;
   logic [31:0]         reg2_i;
   logic                LLbit_i;
   logic [31:0]         rdata_o;
   logic                done_o;
   logic                LLbit_we_o;
   logic                LLbit_value_o;
   logic                stallreq_o;
   logic                bus_err_o;
   logic                bus_req_o;
   logic                bus_we_o;
   logic [ADDR_W-1:0]   bus_addr_o;
   logic [3:0]          bus_sel_o;
   logic [31:0]         bus_wdata_o;
   logic                bus_ack_i;
   logic [31:0]         bus_rdata_i;
   logic                excp_adel_o;
   logic                excp_ades_o;
   logic [1:0]          dbg_state_o;

   mem_lsu #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk           (clk),
      .rst           (rst),
      .valid_i       (valid_i),
      .aluop_i       (aluop_i),
      .mem_addr_i    (mem_addr_i),
      .reg2_i        (reg2_i),
      .LLbit_i       (LLbit_i),
      .rdata_o       (rdata_o),
      .done_o        (done_o),
      .LLbit_we_o    (LLbit_we_o),
      .LLbit_value_o (LLbit_value_o),
      .stallreq_o    (stallreq_o),
      .bus_err_o     (bus_err_o),
      .bus_req_o     (bus_req_o),
      .bus_we_o      (bus_we_o),
      .bus_addr_o    (bus_addr_o),
      .bus_sel_o     (bus_sel_o),
      .bus_wdata_o   (bus_wdata_o),
      .bus_ack_i     (bus_ack_i),
      .bus_rdata_i   (bus_rdata_i),
      .excp_adel_o   (excp_adel_o),
      .excp_ades_o   (excp_ades_o),
      .dbg_state_o   (dbg_state_o)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // scoreboard state
   logic [31:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   // per-access observations filled by run_op
   int          r_stalls;
   int          r_reqs;
   int          r_done_cyc;
   logic        r_done;
   logic        r_err;
   logic        r_llwe;
   logic        r_llval;
   logic        r_adel;
   logic        r_ades;
   logic [31:0] cap_addr;
   logic [3:0]  cap_sel;
   logic [31:0] cap_wdata;
   logic        cap_we;
   logic        cap_stable;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Runs one access. ack_after=N acks in the Nth REQ cycle, 0 never acks.
   // Entered and left just after a rising edge.
   task automatic run_op(input string tag, input logic [ALU_OP_W-1:0] op,
                         input logic [31:0] addr, input logic [31:0] r2,
                         input logic llbit, input int ack_after,
                         input logic [31:0] word);
      valid_i    = 1'b1;
      aluop_i    = op;
      mem_addr_i = addr;
      reg2_i     = r2;
      LLbit_i    = llbit;
      r_stalls   = 0;
      r_reqs     = 0;
      r_done_cyc = -1;
      r_done     = 1'b0;
      r_err      = 1'b0;
      r_llwe     = 1'b0;
      r_llval    = 1'b0;
      r_adel     = 1'b0;
      r_ades     = 1'b0;
      cap_addr   = '0;
      cap_sel    = '0;
      cap_wdata  = '0;
      cap_we     = 1'b0;
      cap_stable = 1'b1;
      for (int cyc = 0; cyc < 64 && !r_done; cyc++) begin
         @(negedge clk);
         if (bus_req_o) begin
            r_reqs++;
            if (r_reqs == 1) begin
               cap_addr  = bus_addr_o;
               cap_sel   = bus_sel_o;
               cap_wdata = bus_wdata_o;
               cap_we    = bus_we_o;
            end else if (bus_addr_o !== cap_addr || bus_sel_o !== cap_sel ||
                         bus_wdata_o !== cap_wdata || bus_we_o !== cap_we) begin
               cap_stable = 1'b0;
            end
            if (ack_after > 0 && r_reqs == ack_after) begin
               bus_ack_i   = 1'b1;
               bus_rdata_i = word;
            end
         end
         if (stallreq_o) r_stalls++;
         if (done_o) begin
            r_done     = 1'b1;
            r_done_cyc = cyc;
            r_err      = bus_err_o;
            r_llwe     = LLbit_we_o;
            r_llval    = LLbit_value_o;
            r_adel     = excp_adel_o;
            r_ades     = excp_ades_o;
            if (exp_q.size() > 0)
               check($sformatf("%s_rdata", tag), rdata_o, exp_q.pop_front());
         end
         @(posedge clk);
         #1;
         bus_ack_i   = 1'b0;
         bus_rdata_i = '0;
      end
      valid_i = 1'b0;
      aluop_i = EXE_OP_NOP;
      LLbit_i = 1'b0;
      check($sformatf("%s_done", tag), 32'(r_done), 32'd1);
      if (!r_done && exp_q.size() > 0) void'(exp_q.pop_front());
   endtask

   initial begin
      // reset block: a live LW is presented during reset and must not stall
      rst         = 1'b1;
      valid_i     = 1'b1;
      aluop_i     = EXE_OP_LOAD_STORE_LW;
      mem_addr_i  = 32'h100;
      reg2_i      = '0;
      LLbit_i     = 1'b0;
      bus_ack_i   = 1'b0;
      bus_rdata_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_stall", 32'(stallreq_o), 32'd0);
      check("rst_req",   32'(bus_req_o),  32'd0);
      check("rst_sel",   32'(bus_sel_o),  32'd0);
      check("rst_done",  32'(done_o),     32'd0);
      check("rst_rdata", rdata_o,         32'd0);
      check("rst_state", 32'(dbg_state_o), 32'(LSU_IDLE));
      @(posedge clk);
      #1;
      rst     = 1'b0;
      valid_i = 1'b0;
      aluop_i = EXE_OP_NOP;
      @(posedge clk);
      #1;

      // LW, ack in 3rd REQ cycle
      exp_q.push_back(32'hDEAD_BEEF);
      run_op("lw", EXE_OP_LOAD_STORE_LW, 32'h100, 32'h0, 1'b0, 3, 32'hDEAD_BEEF);
      check("lw_reqs",    r_reqs,      32'd3);
      check("lw_stalls",  r_stalls,    32'd4);
      check("lw_donecyc", r_done_cyc,  32'd4);
      check("lw_addr",    cap_addr,    32'h100);
      check("lw_sel",     32'(cap_sel), 32'hF);
      check("lw_we",      32'(cap_we), 32'd0);
      check("lw_stable",  32'(cap_stable), 32'd1);

      // SB at 0x203
      exp_q.push_back(32'h0);
      run_op("sb", EXE_OP_LOAD_STORE_SB, 32'h203, 32'h5A, 1'b0, 2, 32'h0);
      check("sb_addr",  cap_addr,  32'h200);
      check("sb_sel",   32'(cap_sel), 32'b1000);
      check("sb_wdata", cap_wdata, 32'h5A5A_5A5A);
      check("sb_we",    32'(cap_we), 32'd1);
      check("sb_stable", 32'(cap_stable), 32'd1);

      // byte / half loads
      exp_q.push_back(32'hFFFF_FFF1);
      run_op("lb", EXE_OP_LOAD_STORE_LB, 32'h01, 32'h0, 1'b0, 1, 32'h0000_F100);
      check("lb_sel", 32'(cap_sel), 32'b0010);
      exp_q.push_back(32'h0000_00F1);
      run_op("lbu", EXE_OP_LOAD_STORE_LBU, 32'h01, 32'h0, 1'b0, 1, 32'h0000_F100);
      exp_q.push_back(32'hFFFF_8001);
      run_op("lh", EXE_OP_LOAD_STORE_LH, 32'h02, 32'h0, 1'b0, 1, 32'h8001_1234);
      check("lh_sel", 32'(cap_sel), 32'b1100);
      exp_q.push_back(32'h0000_F234);
      run_op("lhu", EXE_OP_LOAD_STORE_LHU, 32'h00, 32'h0, 1'b0, 1, 32'h8001_F234);

      // unaligned word merges and partial stores
      exp_q.push_back(32'h2211_CCDD);
      run_op("lwl", EXE_OP_LOAD_STORE_LWL, 32'h11, 32'hAABB_CCDD, 1'b0, 1, 32'h4433_2211);
      check("lwl_sel", 32'(cap_sel), 32'b0011);
      exp_q.push_back(32'hAA44_3322);
      run_op("lwr", EXE_OP_LOAD_STORE_LWR, 32'h21, 32'hAABB_CCDD, 1'b0, 1, 32'h4433_2211);
      check("lwr_sel", 32'(cap_sel), 32'b1110);
      exp_q.push_back(32'h0);
      run_op("swl", EXE_OP_LOAD_STORE_SWL, 32'h31, 32'hAABB_CCDD, 1'b0, 1, 32'h0);
      check("swl_sel",   32'(cap_sel), 32'b0011);
      check("swl_wdata", cap_wdata,    32'h0000_AABB);
      exp_q.push_back(32'h0);
      run_op("swr", EXE_OP_LOAD_STORE_SWR, 32'h32, 32'hAABB_CCDD, 1'b0, 1, 32'h0);
      check("swr_sel",   32'(cap_sel), 32'b1100);
      check("swr_wdata", cap_wdata,    32'hCCDD_0000);
      exp_q.push_back(32'h0);
      run_op("sh", EXE_OP_LOAD_STORE_SH, 32'h206, 32'h0000_1234, 1'b0, 1, 32'h0);
      check("sh_addr",  cap_addr,     32'h204);
      check("sh_sel",   32'(cap_sel), 32'b1100);
      check("sh_wdata", cap_wdata,    32'h1234_1234);

      // LL / SC pair, then a failing SC
      exp_q.push_back(32'h0000_0077);
      run_op("ll", EXE_OP_LOAD_STORE_LL, 32'h40, 32'h0, 1'b0, 1, 32'h0000_0077);
      check("ll_llwe",  32'(r_llwe),  32'd1);
      check("ll_llval", 32'(r_llval), 32'd1);
      exp_q.push_back(32'd1);
      run_op("sc", EXE_OP_LOAD_STORE_SC, 32'h40, 32'h99, 1'b1, 1, 32'h0);
      check("sc_llwe",  32'(r_llwe),  32'd1);
      check("sc_llval", 32'(r_llval), 32'd0);
      check("sc_we",    32'(cap_we),  32'd1);
      check("sc_wdata", cap_wdata,    32'h99);
      check("sc_reqs",  r_reqs,       32'd1);
      exp_q.push_back(32'd0);
      run_op("scf", EXE_OP_LOAD_STORE_SC, 32'h40, 32'h99, 1'b0, 1, 32'h0);
      check("scf_reqs",    r_reqs,      32'd0);
      check("scf_llwe",    32'(r_llwe), 32'd0);
      check("scf_donecyc", r_done_cyc,  32'd1);
      check("scf_stalls",  r_stalls,    32'd1);

      // timeout with no ack
      exp_q.push_back(32'd0);
      run_op("to", EXE_OP_LOAD_STORE_LW, 32'h300, 32'h0, 1'b0, 0, 32'h0);
      check("to_reqs",    r_reqs,      32'd16);
      check("to_err",     32'(r_err),  32'd1);
      check("to_donecyc", r_done_cyc,  32'd17);
      check("to_stalls",  r_stalls,    32'd17);

      // misaligned accesses
`ifdef LSU_ALIGN_EXC_EN
      exp_q.push_back(32'd0);
      run_op("swmis", EXE_OP_LOAD_STORE_SW, 32'h102, 32'h1122_3344, 1'b0, 1, 32'h0);
      check("swmis_reqs", r_reqs,      32'd0);
      check("swmis_ades", 32'(r_ades), 32'd1);
      check("swmis_adel", 32'(r_adel), 32'd0);
      exp_q.push_back(32'd0);
      run_op("lwmis", EXE_OP_LOAD_STORE_LW, 32'h101, 32'h0, 1'b0, 1, 32'hFFFF_FFFF);
      check("lwmis_reqs", r_reqs,      32'd0);
      check("lwmis_adel", 32'(r_adel), 32'd1);
      check("lwmis_llwe", 32'(r_llwe), 32'd0);
`else
      exp_q.push_back(32'd0);
      run_op("swmis", EXE_OP_LOAD_STORE_SW, 32'h102, 32'h1122_3344, 1'b0, 1, 32'h0);
      check("swmis_reqs", r_reqs,       32'd1);
      check("swmis_sel",  32'(cap_sel), 32'd0);
      check("swmis_ades", 32'(r_ades),  32'd0);
      exp_q.push_back(32'd0);
      run_op("lwmis", EXE_OP_LOAD_STORE_LW, 32'h101, 32'h0, 1'b0, 1, 32'hFFFF_FFFF);
      check("lwmis_reqs", r_reqs,      32'd1);
      check("lwmis_adel", 32'(r_adel), 32'd0);
`endif

      // ack while idle is ignored
      bus_ack_i   = 1'b1;
      bus_rdata_i = 32'hFFFF_FFFF;
      @(negedge clk);
      @(negedge clk);
      check("idleack_state", 32'(dbg_state_o), 32'(LSU_IDLE));
      check("idleack_req",   32'(bus_req_o),   32'd0);
      @(posedge clk);
      #1;
      bus_ack_i   = 1'b0;
      bus_rdata_i = '0;

      // flush while in REQ: completes, but no done strobe
      valid_i    = 1'b1;
      aluop_i    = EXE_OP_LOAD_STORE_LL;
      mem_addr_i = 32'h600;
      @(negedge clk);                  // cycle 0, IDLE
      @(negedge clk);                  // cycle 1, REQ
      check("fl_req", 32'(bus_req_o), 32'd1);
      valid_i = 1'b0;
      @(negedge clk);                  // cycle 2, REQ, ack here
      bus_ack_i   = 1'b1;
      bus_rdata_i = 32'h1234_5678;
      @(negedge clk);                  // cycle 3, DONE
      check("fl_state", 32'(dbg_state_o), 32'(LSU_DONE));
      check("fl_done",  32'(done_o),      32'd0);
      check("fl_llwe",  32'(LLbit_we_o),  32'd0);
      check("fl_rdata", rdata_o,          32'd0);
      @(posedge clk);
      #1;
      bus_ack_i   = 1'b0;
      bus_rdata_i = '0;
      aluop_i     = EXE_OP_NOP;
      @(negedge clk);
      check("fl_idle", 32'(dbg_state_o), 32'(LSU_IDLE));
      @(posedge clk);
      #1;

      // reset in the middle of REQ
      valid_i    = 1'b1;
      aluop_i    = EXE_OP_LOAD_STORE_LW;
      mem_addr_i = 32'h500;
      @(negedge clk);                  // cycle 0, IDLE
      @(negedge clk);                  // cycle 1, REQ
      @(negedge clk);                  // cycle 2, REQ
      check("rq_req_before", 32'(bus_req_o), 32'd1);
      rst = 1'b1;
      #1;
      check("rq_stall_in_rst", 32'(stallreq_o), 32'd0);
      @(negedge clk);
      check("rq_req_after", 32'(bus_req_o),   32'd0);
      check("rq_state",     32'(dbg_state_o), 32'(LSU_IDLE));
      @(posedge clk);
      #1;
      rst     = 1'b0;
      valid_i = 1'b0;
      aluop_i = EXE_OP_NOP;
      @(posedge clk);
      #1;

      check("sb_empty", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Multi-cycle load/store unit replacing the single-cycle memory-access stage between EX/MEM and MEM/WB. Handles the full LB/LBU/LH/LHU/LW/LWL/LWR/SB/SH/SW/SWL/SWR/LL/SC set over a request/acknowledge data bus with arbitrary wait states. Stalls the pipeline until the access completes, and aborts hung accesses with a bus-error timeout. Little-endian byte lanes; 32-bit data.

## Interface
Parameters:
- ADDR_W, 32, bus address width
- TIMEOUT, 16, max cycles `bus_req_o` may stay high without `bus_ack_i` (≥2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- valid_i  in  1  EX/MEM holds a live instruction this cycle
- aluop_i  in  `AluOpBus`  load/store opcode (`EXE_OP_LOAD_STORE_*`)
- mem_addr_i  in  ADDR_W  effective address
- reg2_i  in  32  store data / LWL-LWR merge operand
- LLbit_i  in  1  current LLbit, WB-forwarded by the caller
- rdata_o  out  32  load result / SC status, valid while `done_o`
- done_o  out  1  access complete this cycle
- LLbit_we_o, LLbit_value_o  out  1, 1  LLbit update, qualified by `done_o`
- stallreq_o  out  1  hold pipeline
- bus_err_o  out  1  timeout abort, qualified by `done_o`
- bus_req_o  out  1  bus request
- bus_we_o  out  1  write request
- bus_addr_o  out  ADDR_W  word-aligned address (`mem_addr_i` with bits [1:0] cleared)
- bus_sel_o  out  4  byte enables
- bus_wdata_o  out  32  write data
- bus_ack_i  in  1  transfer complete
- bus_rdata_i  in  32  read data, valid with `bus_ack_i`
- excp_adel_o, excp_ades_o  out  1, 1  load/store address error (only with LSU_ALIGN_EXC_EN)

## Operation
- States: IDLE, REQ, DONE.
- IDLE, with `valid_i` and a load/store op: latch op, address, `reg2_i`, and lane/sel/wdata (same lane rules as the existing stage, e.g. SB addr[1:0]=2 gives sel 0100 and data {4{byte}}). Go to REQ.
- SC with `LLbit_i`=0 is the exception: go directly to DONE with no bus access and `rdata_o`=0.
- IDLE, otherwise: stay. `stallreq_o`=0.
- REQ: `bus_req_o`=1 and all bus outputs held stable.
  - On `bus_ack_i`: capture `bus_rdata_i`, form the result (sign/zero extend; LWL/LWR merge with latched `reg2_i`), go to DONE.
  - If the wait counter reaches TIMEOUT-1 without ack: go to DONE with `bus_err_o`=1 and `rdata_o`=0.
- DONE: for one cycle `done_o`=1 and `stallreq_o`=0, so the pipeline advances on this edge. Then go to IDLE.
- `stallreq_o` = `valid_i` & mem-op & (state≠DONE). Non-memory ops never stall.
- LL completion: `LLbit_we_o`=1, `LLbit_value_o`=1. Successful SC: `LLbit_we_o`=1, `LLbit_value_o`=0, `rdata_o`=1. Failed SC and bus error: `LLbit_we_o`=0.
- Wait counter: width $clog2(TIMEOUT). Clears on entry to REQ and saturates.

## Timing
- Reset: state IDLE. All outputs 0, including `bus_req_o`, `bus_sel_o`=0000, `rdata_o`, `done_o`, `stallreq_o` (combinational, 0 while `rst`).
- Latency with ack after n REQ cycles (n≥1): op seen at cycle 0, `bus_req_o` high cycles 1..n, DONE at cycle n+1. Stall lasts n+1 cycles. Failed SC: done at cycle 1, one stall cycle.
- `bus_ack_i` is ignored outside REQ.
- `rst` during REQ: `bus_req_o` drops at the next edge; the access is abandoned and the bus must tolerate the withdrawal.
- `valid_i` may drop during REQ (flush). The access still completes to DONE, but `done_o` is suppressed: no writeback, no LLbit update.
- Ack on the same cycle the timeout fires: the ack wins.

## Configuration
- `LSU_ALIGN_EXC_EN` defined:
  - Misaligned LH/LHU (addr[0]), LW/LL (addr[1:0]≠0), SH, SW, SC go directly to DONE without a bus access.
  - Loads pulse `excp_adel_o`; stores pulse `excp_ades_o`.
  - No LLbit write; `rdata_o`=0.
- Undefined:
  - Exception ports are tied 0.
  - Misaligned loads perform the bus read but return 0.
  - Misaligned stores perform the bus cycle with `bus_sel_o`=0000.

## Structure
- Shared `defines.v` gains state encodings `LSU_IDLE`/`LSU_REQ`/`LSU_DONE`; opcodes stay in the existing `EXE_OP_LOAD_STORE_*` set.
- One sub-module, `lsu_lane`: combinational sel/wdata generation and read extract/extend/merge, shared by the latch and capture paths.

## Test plan
- LW at 0x100, ack after 3 REQ cycles, rdata 0xDEADBEEF → `rdata_o`=0xDEADBEEF, 4 stall cycles, `done_o` at cycle 4.
- SB at 0x203, reg2=0x5A → `bus_addr_o`=0x200, `bus_sel_o`=1000, `bus_wdata_o`=0x5A5A5A5A, `bus_we_o`=1.
- LB at 0x01, bus word 0x0000F100 → `rdata_o`=0xFFFFFFF1; LBU at the same address → 0x000000F1.
- LL at 0x40 then SC with LLbit=1 → `rdata_o`=1, LLbit cleared. Second SC with LLbit=0 → no `bus_req_o`, `rdata_o`=0.
- No ack, TIMEOUT=16 → `bus_req_o` high exactly 16 cycles, `bus_err_o`=1, `rdata_o`=0.
- `LSU_ALIGN_EXC_EN` on, SW at 0x102 → no bus request, `excp_ades_o` pulse. `rst` asserted mid-REQ → `bus_req_o`=0 next cycle.
